// File: rtl/fp_sp_pkg.sv
// Shared types for the single-precision divider front end: operand classes,
// pre-normalizer states and the unpacked-operand record handed to the divider.
package fp_sp_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fpClass_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_NORM_A,
        ST_NORM_B,
        ST_HOLD
    } state_t;

    localparam logic [9:0]  BIAS = 10'd127;
    localparam logic [9:0]  EMIN = 10'h382;  // -126 in 10-bit two's complement
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic       sign;
        logic [9:0] exp;
        logic [23:0] mant;
        fpClass_t   cls;
    } fpOp_t;

endpackage

// File: rtl/fp_sp_classify.sv
// Combinational binary32 decoder: splits one operand into sign, unbiased
// exponent and mantissa, and tags it with its IEEE-754 class.
module fp_sp_classify
    import fp_sp_pkg::*;
(
    input  logic [31:0] i_op,
    output fpOp_t       o_op
);

    logic [7:0]  w_e;
    logic [22:0] w_f;

    assign w_e = i_op[30:23];
    assign w_f = i_op[22:0];

    // Subnormals start at EMIN with a hidden 0; the parent shifts them up.
    always_comb begin
        o_op      = '0;
        o_op.sign = i_op[31];
        o_op.mant = {1'b0, w_f};
        o_op.cls  = CLS_ZERO;
        if (w_e == 8'hFF) begin
            o_op.cls = (w_f == 23'd0) ? CLS_INF : CLS_NAN;
        end else if (w_e == 8'h00) begin
            if (w_f != 23'd0) begin
                o_op.cls = CLS_SUB;
                o_op.exp = EMIN;
            end
        end else begin
            o_op.cls  = CLS_NORM;
            o_op.exp  = {2'b00, w_e} - BIAS;
            o_op.mant = {1'b1, w_f};
        end
    end

endmodule

// File: rtl/fp_sp_prenorm.sv
// Divider operand pre-normalizer: classifies both operands, resolves special
// quotients, and left-justifies subnormal mantissas through one shared shifter.
module fp_sp_prenorm
    import fp_sp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        a_sign,
    output logic        b_sign,
    output logic [9:0]  a_exp,
    output logic [9:0]  b_exp,
    output logic [23:0] a_mant,
    output logic [23:0] b_mant,
    output logic [2:0]  a_class,
    output logic [2:0]  b_class,
    output logic        special,
    output logic [31:0] special_z
);

    state_t      r_state, w_next;
    logic [31:0] r_a, r_b;
    fpOp_t       r_opA, r_opB;
    fpOp_t       w_opA, w_opB;
    logic        r_special, w_special;
    logic [31:0] r_specialZ, w_specialZ;
    logic        w_sign;

    fp_sp_classify u_classA (.i_op(r_a), .o_op(w_opA));
    fp_sp_classify u_classB (.i_op(r_b), .o_op(w_opB));

    // Checks are ordered so NaN propagation beats the infinity/zero quotients.
    always_comb begin
        w_sign     = w_opA.sign ^ w_opB.sign;
        w_special  = 1'b1;
        w_specialZ = QNAN;
        if (w_opA.cls == CLS_NAN || w_opB.cls == CLS_NAN) begin
            w_specialZ = QNAN;
        end else if ((w_opA.cls == CLS_INF && w_opB.cls == CLS_INF) ||
                     (w_opA.cls == CLS_ZERO && w_opB.cls == CLS_ZERO)) begin
            w_specialZ = QNAN;
        end else if (w_opA.cls == CLS_INF || w_opB.cls == CLS_ZERO) begin
            w_specialZ = {w_sign, 8'hFF, 23'h0};
        end else if (w_opA.cls == CLS_ZERO || w_opB.cls == CLS_INF) begin
            w_specialZ = {w_sign, 31'h0};
        end else begin
            w_special  = 1'b0;
            w_specialZ = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // A normalize state exits on the same edge that sets mant[23], so each
    // subnormal costs exactly its leading-zero count in cycles.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (in_valid) w_next = ST_CLASSIFY;
            ST_CLASSIFY: begin
                if (w_special)                 w_next = ST_HOLD;
                else if (w_opA.cls == CLS_SUB) w_next = ST_NORM_A;
                else if (w_opB.cls == CLS_SUB) w_next = ST_NORM_B;
                else                           w_next = ST_HOLD;
            end
            ST_NORM_A:
                if (r_opA.mant[23] || r_opA.mant[22])
                    w_next = (r_opB.cls == CLS_SUB) ? ST_NORM_B : ST_HOLD;
            ST_NORM_B:
                if (r_opB.mant[23] || r_opB.mant[22]) w_next = ST_HOLD;
            ST_HOLD:     if (out_ready) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a        <= 32'h0;
            r_b        <= 32'h0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_special  <= 1'b0;
            r_specialZ <= 32'h0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a <= i_a;
                        r_b <= i_b;
                    end
                end
                ST_CLASSIFY: begin
                    r_opA      <= w_opA;
                    r_opB      <= w_opB;
                    r_special  <= w_special;
                    r_specialZ <= w_specialZ;
                end
                ST_NORM_A: begin
                    if (!r_opA.mant[23]) begin
                        r_opA.mant <= {r_opA.mant[22:0], 1'b0};
                        r_opA.exp  <= r_opA.exp - 10'd1;
                    end
                end
                ST_NORM_B: begin
                    if (!r_opB.mant[23]) begin
                        r_opB.mant <= {r_opB.mant[22:0], 1'b0};
                        r_opB.exp  <= r_opB.exp - 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_sign    = r_opA.sign;
    assign b_sign    = r_opB.sign;
    assign a_exp     = r_opA.exp;
    assign b_exp     = r_opB.exp;
    assign a_mant    = r_opA.mant;
    assign b_mant    = r_opB.mant;
    assign a_class   = r_opA.cls;
    assign b_class   = r_opB.cls;
    assign special   = r_special;
    assign special_z = r_specialZ;

endmodule

// File: tb/tb_fp_sp_prenorm.sv
// Bench for the divider pre-normalizer: directed vectors, randomized operands
// against an arithmetic model, backpressure and mid-operation reset.
module tb_fp_sp_prenorm;

    localparam int LAT_LIMIT = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] i_a = 32'h0;
    logic [31:0] i_b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        a_sign, b_sign;
    logic [9:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    logic [2:0]  a_class, b_class;
    logic        special;
    logic [31:0] special_z;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    fp_sp_prenorm dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .i_a(i_a), .i_b(i_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_mant(a_mant), .b_mant(b_mant),
        .a_class(a_class), .b_class(b_class),
        .special(special), .special_z(special_z)
    );

    // Reference decode: normalize by repeated doubling of the fraction value.
    function automatic void modelOp(input logic [31:0] x, output logic s, output int ex,
                                    output logic [23:0] m, output logic [2:0] c, output int lz);
        int e;
        int f;
        int mm;
        s  = x[31];
        e  = int'(x[30:23]);
        f  = int'(x[22:0]);
        lz = 0;
        ex = 0;
        m  = 24'(f);
        c  = 3'd0;
        if (e == 255) begin
            c = (f == 0) ? 3'd3 : 3'd4;
        end else if (e == 0) begin
            if (f != 0) begin
                c  = 3'd1;
                mm = f;
                ex = -126;
                while (mm < 8388608) begin
                    mm = mm * 2;
                    ex = ex - 1;
                    lz = lz + 1;
                end
                m = 24'(mm);
            end
        end else begin
            c  = 3'd2;
            ex = e - 127;
            m  = 24'(f + 8388608);
        end
    endfunction

    function automatic void modelSpecial(input logic [2:0] ca, input logic [2:0] cb, input logic s,
                                         output logic sp, output logic [31:0] z);
        sp = 1'b1;
        if (ca == 3'd4 || cb == 3'd4)                              z = 32'h7FC00000;
        else if ((ca == 3'd3 && cb == 3'd3) || (ca == 3'd0 && cb == 3'd0)) z = 32'h7FC00000;
        else if (ca == 3'd3 || cb == 3'd0)                         z = {s, 8'hFF, 23'h0};
        else if (ca == 3'd0 || cb == 3'd3)                         z = {s, 31'h0};
        else begin
            sp = 1'b0;
            z  = 32'h0;
        end
    endfunction

    function automatic logic [31:0] randOp();
        int          k;
        logic        s;
        logic [22:0] f;
        logic [31:0] x;
        k = int'($urandom_range(0, 7));
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case (k)
            0: x = {s, 8'h00, 23'h0};
            1, 2, 3: begin
                f = f >> $urandom_range(0, 22);
                if (f == 23'd0) f = 23'd1;
                x = {s, 8'h00, f};
            end
            4, 5: x = {s, 8'($urandom_range(1, 254)), f};
            6: x = {s, 8'hFF, 23'h0};
            default: begin
                if (f == 23'd0) f = 23'd1;
                x = {s, 8'hFF, f};
            end
        endcase
        return x;
    endfunction

    // Offers one operand pair and returns the cycle index (accept cycle = 0)
    // in which out_valid is first seen; leaves the result parked in HOLD.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
        in_valid = 1'b1;
        i_a = a;
        i_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        i_a = $urandom;
        i_b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < LAT_LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finishTransfer();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #2;
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        nVec++; if (in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        nVec++; if ({a_exp, b_exp, a_mant, b_mant, a_class, b_class, special, special_z} !== '0) begin
            nErr++; $display("[TB] FAIL reset_data: got a_mant=%h b_mant=%h special_z=%h want 0", a_mant, b_mant, special_z);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        int lat;
        applyStimulus(32'h40C00000, 32'h3FC00000, lat);
        nVec++; if (lat !== 2) begin nErr++; $display("[TB] FAIL normal_latency: got %0d want 2", lat); end
        nVec++; if (a_exp !== 10'd2 || b_exp !== 10'd0) begin nErr++; $display("[TB] FAIL normal_exp: got a=%h b=%h want 002 000", a_exp, b_exp); end
        nVec++; if (a_mant !== 24'hC00000 || b_mant !== 24'hC00000) begin nErr++; $display("[TB] FAIL normal_mant: got a=%h b=%h want c00000", a_mant, b_mant); end
        nVec++; if (a_class !== 3'd2 || b_class !== 3'd2 || special !== 1'b0) begin
            nErr++; $display("[TB] FAIL normal_class: got a=%0d b=%0d special=%b want 2 2 0", a_class, b_class, special);
        end
        nVec++; if (in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL normal_in_ready_hold: got %b want 0", in_ready); end
        finishTransfer();
        nVec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nErr++; $display("[TB] FAIL normal_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_subnormal();
        int lat;
        applyStimulus(32'h00000001, 32'h3F800000, lat);
        nVec++; if (lat !== 25) begin nErr++; $display("[TB] FAIL sub_latency: got %0d want 25", lat); end
        nVec++; if (a_class !== 3'd1 || a_mant !== 24'h800000) begin nErr++; $display("[TB] FAIL sub_a: got class=%0d mant=%h want 1 800000", a_class, a_mant); end
        nVec++; if (a_exp !== 10'(-149) || b_exp !== 10'd0) begin nErr++; $display("[TB] FAIL sub_exp: got a=%h b=%h want 36b 000", a_exp, b_exp); end
        finishTransfer();
        applyStimulus(32'h00400000, 32'h00000003, lat);
        nVec++; if (lat !== 25) begin nErr++; $display("[TB] FAIL twosub_latency: got %0d want 25", lat); end
        nVec++; if (a_exp !== 10'(-127) || a_mant !== 24'h800000) begin nErr++; $display("[TB] FAIL twosub_a: got exp=%h mant=%h want 381 800000", a_exp, a_mant); end
        nVec++; if (b_exp !== 10'(-148) || b_mant !== 24'hC00000 || b_class !== 3'd1) begin
            nErr++; $display("[TB] FAIL twosub_b: got exp=%h mant=%h class=%0d want 36c c00000 1", b_exp, b_mant, b_class);
        end
        finishTransfer();
    endtask

    task automatic test_specials();
        logic [31:0] va[6] = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h7FA00000, 32'h7FA00000, 32'h80000000};
        logic [31:0] vb[6] = '{32'h00000000, 32'h00000000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'h3F800000};
        logic [31:0] vz[6] = '{32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
        int lat;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(va[i], vb[i], lat);
            nVec++; if (special !== 1'b1 || special_z !== vz[i] || lat !== 2) begin
                nErr++; $display("[TB] FAIL special_%0d: got special=%b z=%h lat=%0d want 1 %h 2", i, special, special_z, lat, vz[i]);
            end
            finishTransfer();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, ez;
        logic        sa, sb, esp;
        int          ea, eb, lza, lzb, lat, wantLat;
        logic [23:0] ma, mb;
        logic [2:0]  ca, cb;
        for (int n = 0; n < 60; n++) begin
            a = randOp();
            b = randOp();
            modelOp(a, sa, ea, ma, ca, lza);
            modelOp(b, sb, eb, mb, cb, lzb);
            modelSpecial(ca, cb, sa ^ sb, esp, ez);
            wantLat = esp ? 2 : 2 + lza + lzb;
            applyStimulus(a, b, lat);
            nVec++; if (lat !== wantLat) begin nErr++; $display("[TB] FAIL rand_latency a=%h b=%h: got %0d want %0d", a, b, lat, wantLat); end
            nVec++; if (a_sign !== sa || b_sign !== sb || a_class !== ca || b_class !== cb) begin
                nErr++; $display("[TB] FAIL rand_class a=%h b=%h: got %b%b %0d %0d want %b%b %0d %0d", a, b, a_sign, b_sign, a_class, b_class, sa, sb, ca, cb);
            end
            nVec++; if (special !== esp || (esp && special_z !== ez)) begin
                nErr++; $display("[TB] FAIL rand_special a=%h b=%h: got %b %h want %b %h", a, b, special, special_z, esp, ez);
            end
            if (!esp) begin
                nVec++; if (a_exp !== 10'(ea) || a_mant !== ma) begin
                    nErr++; $display("[TB] FAIL rand_a a=%h: got exp=%h mant=%h want %h %h", a, a_exp, a_mant, 10'(ea), ma);
                end
                nVec++; if (b_exp !== 10'(eb) || b_mant !== mb) begin
                    nErr++; $display("[TB] FAIL rand_b b=%h: got exp=%h mant=%h want %h %h", b, b_exp, b_mant, 10'(eb), mb);
                end
            end
            finishTransfer();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic bad;
        applyStimulus(32'h40C00000, 32'h3FC00000, lat);
        bad = 1'b0;
        in_valid = 1'b1;
        i_a = 32'h3F800000;
        i_b = 32'h00000001;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || a_exp !== 10'd2 || b_exp !== 10'd0 ||
                a_mant !== 24'hC00000 || b_mant !== 24'hC00000 || special !== 1'b0) bad = 1'b1;
        end
        nVec++; if (bad) begin nErr++; $display("[TB] FAIL backpressure_stable: got ov=%b ir=%b a_exp=%h b_exp=%h want 1 0 002 000", out_valid, in_ready, a_exp, b_exp); end
        in_valid = 1'b0;
        finishTransfer();
        nVec++; if (a_exp !== 10'd2 || a_mant !== 24'hC00000) begin nErr++; $display("[TB] FAIL backpressure_transfer: got %h %h want 002 c00000", a_exp, a_mant); end
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        nVec++; if (bad) begin nErr++; $display("[TB] FAIL backpressure_ignored_input: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_midop();
        int lat;
        logic bad;
        in_valid = 1'b1;
        i_a = 32'h00000001;
        i_b = 32'h3F800000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        nVec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL midreset_handshake: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
        nVec++; if (a_mant !== 24'h0 || a_exp !== 10'h0 || a_class !== 3'd0) begin
            nErr++; $display("[TB] FAIL midreset_data: got mant=%h exp=%h class=%0d want 0", a_mant, a_exp, a_class);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        bad = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        nVec++; if (bad) begin nErr++; $display("[TB] FAIL midreset_dropped: got out_valid=1 want 0"); end
        applyStimulus(32'h40C00000, 32'h3FC00000, lat);
        nVec++; if (lat !== 2 || a_exp !== 10'd2 || b_exp !== 10'd0 || a_mant !== 24'hC00000 || b_mant !== 24'hC00000) begin
            nErr++; $display("[TB] FAIL midreset_recover: got lat=%0d a_exp=%h b_exp=%h a_mant=%h want 2 002 000 c00000", lat, a_exp, b_exp, a_mant);
        end
        finishTransfer();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_subnormal();
        test_specials();
        test_random();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
